// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the pipeline hazard control logic.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    MWAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_X0       = 5'd0;
  localparam int         MAX_BR_FLUSH = 4;
  localparam int         FLUSH_CNT_W  = $clog2(MAX_BR_FLUSH + 1);

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall/flush cycle counters for hazard_ctrl; they wrap on overflow.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_cycles_o
);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc_i) stall_d = stall_q + 1'b1;
    if (flush_inc_i) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_cycles_o = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch squash, memory-wait freeze.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles,
`endif
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_stall
);

  if (BR_FLUSH_CYCLES < 1 || BR_FLUSH_CYCLES > MAX_BR_FLUSH) begin : g_bad_br
    $error("hazard_ctrl: BR_FLUSH_CYCLES out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("hazard_ctrl: CNT_W must be positive");
  end

  localparam logic [FLUSH_CNT_W-1:0] BR_RELOAD = FLUSH_CNT_W'(BR_FLUSH_CYCLES - 1);

  hz_state_t              state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   memWait;
  logic                   loadUse;

  assign memWait = dmem_req && !dmem_ready;
  assign loadUse = ex_mem_read && (ex_rd != REG_X0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Memory wait overrides everything; a branch seen while frozen is re-seen once RUN resumes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    if (memWait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_hold   = 1'b1;
      ex_mem_stall = 1'b1;
      state_d      = MWAIT;
    end else begin
      case (state_q)
        MWAIT: state_d = RUN;
        FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          cnt_d       = cnt_q - 1'b1;
          if (cnt_q <= 1) state_d = RUN;
        end
        default: begin
          if (ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (BR_FLUSH_CYCLES > 1) begin
              cnt_d   = BR_RELOAD;
              state_d = FLUSH;
            end
          end else if (loadUse) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
      endcase
    end
    if (!rst) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_hold   = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk           (clk),
    .rst           (rst),
    .stall_inc_i   (pc_stall),
    .flush_inc_i   (id_ex_flush),
    .stall_cycles_o(stall_cycles),
    .flush_cycles_o(flush_cycles)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl built with BR_FLUSH_CYCLES=2.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_br_taken, dmem_req, dmem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_stall;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int errors = 0;
  int checks = 0;

  // Control bundle order: {pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_stall}
  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] LDUSE = 6'b110010;
  localparam logic [5:0] BRFL  = 6'b001010;
  localparam logic [5:0] MEMW  = 6'b110101;

  logic [5:0] ctl;
  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_stall};

  always #5 clk = ~clk;

  hazard_ctrl #(
    .BR_FLUSH_CYCLES(2),
    .CNT_W          (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_br_taken (ex_br_taken),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles),
`endif
    .pc_stall    (pc_stall),
    .if_id_stall (if_id_stall),
    .if_id_flush (if_id_flush),
    .id_ex_hold  (id_ex_hold),
    .id_ex_flush (id_ex_flush),
    .ex_mem_stall(ex_mem_stall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                               input logic u2, input logic [4:0] rd, input logic mr,
                               input logic br, input logic req, input logic rdy);
    id_rs1      = rs1;
    id_uses_rs1 = u1;
    id_rs2      = rs2;
    id_uses_rs2 = u2;
    ex_rd       = rd;
    ex_mem_read = mr;
    ex_br_taken = br;
    dmem_req    = req;
    dmem_ready  = rdy;
  endtask

  // Check controls mid-cycle, then advance to just after the next rising edge.
  task automatic checkCycle(input string tag, input logic [5:0] expected);
    @(negedge clk);
    checkOutput(tag, {26'd0, ctl}, {26'd0, expected});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkCycle("reset_forces_zero", NONE);

    rst = 1'b1;
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCycle("idle", NONE);

    // Load-use on rs1, then load gone
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCycle("loaduse_rs1", LDUSE);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    checkOutput("perf_stall_after_t1", stall_cycles, 32'd1);
    checkOutput("perf_flush_after_t1", flush_cycles, 32'd1);
`endif
    checkCycle("loaduse_cleared", NONE);

    applyStimulus(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCycle("loaduse_rs2", LDUSE);

    // x0 and unused-operand cases never stall
    applyStimulus(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCycle("x0_no_stall", NONE);
    applyStimulus(5'd3, 1'b1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCycle("rs2_unused", NONE);
    applyStimulus(5'd9, 1'b0, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCycle("rs1_unused", NONE);
    applyStimulus(5'd9, 1'b1, 5'd4, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCycle("not_a_load", NONE);

    // Branch: two flush cycles; branch seen in FLUSH is ignored
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkCycle("br_cycle1", BRFL);
    checkCycle("br_cycle2_ignores_br", BRFL);
    ex_br_taken = 1'b0;
    checkCycle("br_back_to_run", NONE);

    // Memory wait with branch held throughout
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkCycle("mwait_1", MEMW);
    checkCycle("mwait_2", MEMW);
    checkCycle("mwait_3", MEMW);
    dmem_ready = 1'b1;
    checkCycle("mwait_ready", NONE);
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
    checkCycle("mwait_br_first_run", BRFL);
    ex_br_taken = 1'b0;
    checkCycle("mwait_br_flush2", BRFL);
    checkCycle("mwait_br_done", NONE);

    // Branch and load-use together
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checkCycle("br_plus_loaduse", BRFL);
    ex_br_taken = 1'b0;
    checkCycle("br_plus_loaduse_flush2", BRFL);
    ex_mem_read = 1'b0;
    checkCycle("br_plus_loaduse_done", NONE);

    // Reset during MWAIT returns to RUN
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkCycle("mwait_before_reset", MEMW);
    rst = 1'b0;
    checkCycle("reset_in_mwait", NONE);
    rst = 1'b1;
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkCycle("post_reset_run_br", BRFL);
    ex_br_taken = 1'b0;
    checkCycle("post_reset_flush2", BRFL);
    checkCycle("post_reset_idle", NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
